alu_sequencer: RTL and testbench

- Drives the combinational ALU and consumes its result and flags.
- Accepts one decoded RV32I integer or branch operation per valid/ready handshake.
- Maps funct3/funct7 to the ALU's 4-bit control code, registers operands, and captures out/zero/neg/carry/overflow.
- Evaluates branch conditions from the flags and returns the result on a valid/ready response channel to writeback/PC logic.

---
 rtl/alu_sequencer_if.sv | 66 ++++++
 rtl/alu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Bundles the three channels around the ALU sequencer:
//   request  : req_valid/req_ready handshake plus decoded RV32I fields
//              (kind, funct3, funct7b5, rs1, rs2, imm, rd)
//   alu      : registered operands/control out to the combinational ALU,
//              result and zero/neg/carry/overflow flags back
//   response : rsp_valid/rsp_ready handshake plus result, rd, branch,
//              taken and illegal indications
// Modports:
//   slave  - the sequencer (consumes requests, drives ALU and responses)
//   master - the surrounding pipeline (decoder, ALU, writeback/PC logic)
interface alu_sequencer_if #(
    parameter int WIDTH = 32
);
    // request channel
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [2:0]       req_funct3;
    logic             req_funct7b5;
    logic [WIDTH-1:0] req_rs1;
    logic [WIDTH-1:0] req_rs2;
    logic [WIDTH-1:0] req_imm;
    logic [4:0]       req_rd;

    // ALU channel
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_carry;
    logic             alu_overflow;

    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [4:0]       rsp_rd;
    logic             rsp_is_branch;
    logic             rsp_taken;
    logic             rsp_illegal;

    modport slave (
        input  req_valid, req_kind, req_funct3, req_funct7b5,
               req_rs1, req_rs2, req_imm, req_rd,
        output req_ready,
        output alu_a, alu_b, alu_control,
        input  alu_out, alu_zero, alu_neg, alu_carry, alu_overflow,
        output rsp_valid, rsp_result, rsp_rd, rsp_is_branch,
               rsp_taken, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_kind, req_funct3, req_funct7b5,
               req_rs1, req_rs2, req_imm, req_rd,
        input  req_ready,
        input  alu_a, alu_b, alu_control,
        output alu_out, alu_zero, alu_neg, alu_carry, alu_overflow,
        input  rsp_valid, rsp_result, rsp_rd, rsp_is_branch,
               rsp_taken, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Sequences one decoded RV32I integer/branch operation at a time through an
// external combinational ALU. A request is decoded into ALU operands and a
// 4-bit control code, held in registers for one full EXEC cycle, and the
// ALU result/flags are captured into a response that is held until the
// consumer accepts it. Branch conditions are evaluated from the flags of
// the subtraction rs1 - rs2.
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - alu_sequencer_if.slave: request, ALU and response channels
//   op_count  - number of completed responses, wraps modulo 2^CNT_W
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_sequencer_if.slave     bus,
    output logic [CNT_W-1:0]   op_count
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;

    localparam logic [1:0] KIND_R      = 2'b00;
    localparam logic [1:0] KIND_I      = 2'b01;
    localparam logic [1:0] KIND_BRANCH = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;

    // operation held across EXEC
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       control_reg;
    logic [4:0]       rd_reg;
    logic [2:0]       funct3_reg;
    logic             branch_reg;
    logic             illegal_reg;

    // response registers
    logic [WIDTH-1:0] rsp_result_reg;
    logic [4:0]       rsp_rd_reg;
    logic             rsp_is_branch_reg;
    logic             rsp_taken_reg;
    logic             rsp_illegal_reg;
    logic [CNT_W-1:0] op_count_reg;

    // request decode
    logic [3:0]       dec_control;
    logic [WIDTH-1:0] dec_b;
    logic             dec_illegal;
    logic             dec_branch;
    logic             req_fire;

    // branch evaluation from the live ALU flags during EXEC
    logic             branch_cond;

    assign req_fire = bus.req_valid && (state_reg == IDLE);

    always_comb begin
        dec_control = ALU_ADD;
        dec_b       = bus.req_rs2;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        unique case (bus.req_kind)
            KIND_R, KIND_I: begin
                if (bus.req_kind == KIND_I) begin
                    dec_b = bus.req_imm;
                end
                unique case (bus.req_funct3)
                    3'b000: begin
                        // bit 30 selects SUB only for register-register ops;
                        // for ADDI it is just part of the immediate
                        if (bus.req_kind == KIND_R && bus.req_funct7b5) begin
                            dec_control = ALU_SUB;
                        end
                    end
                    3'b001:  dec_control = ALU_SLL;
                    3'b010:  dec_control = ALU_SLT;
                    3'b011:  dec_control = ALU_SLTU;
                    3'b100:  dec_control = ALU_XOR;
                    3'b110:  dec_control = ALU_OR;
                    3'b111:  dec_control = ALU_AND;
                    default: dec_illegal = 1'b1;   // 101: shift-right unsupported
                endcase
            end
            KIND_BRANCH: begin
                dec_branch = 1'b1;
                if (bus.req_funct3 == 3'b010 || bus.req_funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_control = ALU_SUB;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // carry is the borrow of rs1 - rs2, so it flags an unsigned rs1 < rs2
    always_comb begin
        branch_cond = 1'b0;
        unique case (funct3_reg)
            3'b000:  branch_cond = bus.alu_zero;
            3'b001:  branch_cond = ~bus.alu_zero;
            3'b100:  branch_cond = bus.alu_neg ^ bus.alu_overflow;
            3'b101:  branch_cond = ~(bus.alu_neg ^ bus.alu_overflow);
            3'b110:  branch_cond = bus.alu_carry;
            3'b111:  branch_cond = ~bus.alu_carry;
            default: branch_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            a_reg             <= '0;
            b_reg             <= '0;
            control_reg       <= ALU_ADD;
            rd_reg            <= '0;
            funct3_reg        <= '0;
            branch_reg        <= 1'b0;
            illegal_reg       <= 1'b0;
            rsp_result_reg    <= '0;
            rsp_rd_reg        <= '0;
            rsp_is_branch_reg <= 1'b0;
            rsp_taken_reg     <= 1'b0;
            rsp_illegal_reg   <= 1'b0;
            op_count_reg      <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        a_reg       <= bus.req_rs1;
                        b_reg       <= dec_b;
                        control_reg <= dec_control;
                        rd_reg      <= bus.req_rd;
                        funct3_reg  <= bus.req_funct3;
                        branch_reg  <= dec_branch;
                        illegal_reg <= dec_illegal;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    // operands have been stable for the whole cycle; sample
                    // the ALU now. Branches and illegal ops return no result.
                    rsp_result_reg    <= (branch_reg || illegal_reg) ? '0 : bus.alu_out;
                    rsp_rd_reg        <= rd_reg;
                    rsp_is_branch_reg <= branch_reg;
                    rsp_taken_reg     <= branch_reg && !illegal_reg && branch_cond;
                    rsp_illegal_reg   <= illegal_reg;
                    state_reg         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        op_count_reg <= op_count_reg + CNT_ONE;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // handshake outputs decode directly from the state register so they
    // follow an asynchronous reset immediately
    assign bus.req_ready     = (state_reg == IDLE);
    assign bus.rsp_valid     = (state_reg == RESP);

    assign bus.alu_a         = a_reg;
    assign bus.alu_b         = b_reg;
    assign bus.alu_control   = control_reg;

    assign bus.rsp_result    = rsp_result_reg;
    assign bus.rsp_rd        = rsp_rd_reg;
    assign bus.rsp_is_branch = rsp_is_branch_reg;
    assign bus.rsp_taken     = rsp_taken_reg;
    assign bus.rsp_illegal   = rsp_illegal_reg;

    assign op_count          = op_count_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Drives two sequencer instances in lockstep (CNT_W=16 and CNT_W=2), each
// attached to a behavioural ALU, and compares every response against a
// reference computed directly from the RV32I operation semantics.
module tb_alu_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] op_count;
    logic [1:0]  op_count2;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;
    int txn = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(W)) bus ();
    alu_sequencer_if #(.WIDTH(W)) bus2 ();

    alu_sequencer #(.WIDTH(W), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    alu_sequencer #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus2.slave),
        .op_count (op_count2)
    );

    // second instance sees the same request/response traffic
    assign bus2.req_valid    = bus.req_valid;
    assign bus2.req_kind     = bus.req_kind;
    assign bus2.req_funct3   = bus.req_funct3;
    assign bus2.req_funct7b5 = bus.req_funct7b5;
    assign bus2.req_rs1      = bus.req_rs1;
    assign bus2.req_rs2      = bus.req_rs2;
    assign bus2.req_imm      = bus.req_imm;
    assign bus2.req_rd       = bus.req_rd;
    assign bus2.rsp_ready    = bus.rsp_ready;

    // behavioural ALU: returns {overflow, carry, neg, zero, out}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] ctl);
        logic [32:0] wide;
        logic [31:0] o;
        logic        c;
        logic        v;
        wide = '0;
        o = '0;
        c = 1'b0;
        v = 1'b0;
        case (ctl)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                o = wide[31:0];
                c = wide[32];
                v = (a[31] == b[31]) && (o[31] != a[31]);
            end
            4'd1: begin
                o = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (o[31] != a[31]);
            end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5: o = a ^ b;
            4'd6: o = (a < b) ? 32'd1 : 32'd0;
            4'd7: o = a << b[4:0];
            default: o = '0;
        endcase
        return {v, c, o[31], (o == 32'd0), o};
    endfunction

    always_comb begin
        logic [35:0] r;
        r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_control);
        bus.alu_out      = r[31:0];
        bus.alu_zero     = r[32];
        bus.alu_neg      = r[33];
        bus.alu_carry    = r[34];
        bus.alu_overflow = r[35];
    end

    always_comb begin
        logic [35:0] r;
        r = alu_fn(bus2.alu_a, bus2.alu_b, bus2.alu_control);
        bus2.alu_out      = r[31:0];
        bus2.alu_zero     = r[32];
        bus2.alu_neg      = r[33];
        bus2.alu_carry    = r[34];
        bus2.alu_overflow = r[35];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    // reference: RV32I semantics on the raw request fields
    task automatic ref_model(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm,
                             output logic [31:0] res, output logic taken,
                             output logic ill, output logic br, output logic [3:0] ctl);
        logic [31:0] op2;
        op2   = (kind == 2'b01) ? imm : rs2;
        br    = (kind == 2'b10);
        ill   = (kind == 2'b11) || (kind != 2'b10 && f3 == 3'd5) ||
                (kind == 2'b10 && (f3 == 3'd2 || f3 == 3'd3));
        res   = '0;
        taken = 1'b0;
        ctl   = 4'd0;
        if (!ill && br) begin
            ctl = 4'd1;
            case (f3)
                3'd0: taken = (rs1 == rs2);
                3'd1: taken = (rs1 != rs2);
                3'd4: taken = ($signed(rs1) < $signed(rs2));
                3'd5: taken = ($signed(rs1) >= $signed(rs2));
                3'd6: taken = (rs1 < rs2);
                3'd7: taken = (rs1 >= rs2);
                default: taken = 1'b0;
            endcase
        end else if (!ill) begin
            case (f3)
                3'd0: begin
                    if (kind == 2'b00 && f7) begin
                        res = rs1 - op2;
                        ctl = 4'd1;
                    end else begin
                        res = rs1 + op2;
                        ctl = 4'd0;
                    end
                end
                3'd1: begin res = rs1 << op2[4:0]; ctl = 4'd7; end
                3'd2: begin res = ($signed(rs1) < $signed(op2)) ? 32'd1 : 32'd0; ctl = 4'd4; end
                3'd3: begin res = (rs1 < op2) ? 32'd1 : 32'd0; ctl = 4'd6; end
                3'd4: begin res = rs1 ^ op2; ctl = 4'd5; end
                3'd6: begin res = rs1 | op2; ctl = 4'd3; end
                3'd7: begin res = rs1 & op2; ctl = 4'd2; end
                default: res = '0;
            endcase
        end
    endtask

    task automatic do_op(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd, input int stall);
        logic [31:0] e_res;
        logic        e_taken;
        logic        e_ill;
        logic        e_br;
        logic [3:0]  e_ctl;
        logic [40:0] snap;
        ref_model(kind, f3, f7, rs1, rs2, imm, e_res, e_taken, e_ill, e_br, e_ctl);
        txn++;

        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_kind     = kind;
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_rs1      = rs1;
        bus.req_rs2      = rs2;
        bus.req_imm      = imm;
        bus.req_rd       = rd;
        bus.rsp_ready    = (stall == 0);

        // handshake edge; scramble the request so only latched values count
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_rs1    = $urandom;
        bus.req_rs2    = $urandom;
        bus.req_imm    = $urandom;
        bus.req_rd     = 5'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_kind   = 2'($urandom);
        chk("exec_control", bus.alu_control, e_ctl);
        chk("exec_alu_a", bus.alu_a, rs1);
        if (!e_ill) chk("exec_alu_b", bus.alu_b, (kind == 2'b01) ? imm : rs2);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_req_ready", bus.req_ready, 0);

        @(posedge clk);
        #1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_result", bus.rsp_result, e_res);
        chk("rsp_rd", bus.rsp_rd, rd);
        chk("rsp_is_branch", bus.rsp_is_branch, e_br);
        chk("rsp_taken", bus.rsp_taken, e_taken);
        chk("rsp_illegal", bus.rsp_illegal, e_ill);
        chk("resp_req_ready", bus.req_ready, 0);
        chk("resp_alu_a_hold", bus.alu_a, rs1);
        chk("dut2_rsp_result", bus2.rsp_result, e_res);
        snap = {bus.rsp_result, bus.rsp_rd, bus.rsp_is_branch, bus.rsp_taken, bus.rsp_illegal};

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rsp_hold",
                {bus.rsp_result, bus.rsp_rd, bus.rsp_is_branch, bus.rsp_taken, bus.rsp_illegal},
                snap);
            chk("stall_rsp_valid", bus.rsp_valid, 1);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_op_count", op_count, 64'(exp_count % 65536));
        end
        bus.rsp_ready = 1'b1;

        @(posedge clk);
        #1;
        exp_count++;
        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_req_ready", bus.req_ready, 1);
        chk("op_count", op_count, 64'(exp_count % 65536));
        chk("op_count_w2", op_count2, 64'(exp_count % 4));
        $display("txn %0d kind=%0d f3=%0d f7=%0b rs1=%h rs2=%h imm=%h rd=%0d stall=%0d -> res=%h br=%0b taken=%0b ill=%0b count=%0d",
                 txn, kind, f3, f7, rs1, rs2, imm, rd, stall, bus.rsp_result,
                 bus.rsp_is_branch, bus.rsp_taken, bus.rsp_illegal, op_count);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_kind     = 2'b00;
        bus.req_funct3   = 3'd0;
        bus.req_funct7b5 = 1'b0;
        bus.req_rs1      = '0;
        bus.req_rs2      = '0;
        bus.req_imm      = '0;
        bus.req_rd       = '0;
        bus.rsp_ready    = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_control", bus.alu_control, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1);

        // directed cases
        do_op(2'b00, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd3, 0);
        do_op(2'b00, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd3, 3);
        do_op(2'b01, 3'd0, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd4, 0);
        do_op(2'b10, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
        do_op(2'b10, 3'd4, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
        do_op(2'b10, 3'd5, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
        do_op(2'b10, 3'd1, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
        do_op(2'b10, 3'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd0, 0);
        do_op(2'b10, 3'd4, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd0, 0);
        do_op(2'b00, 3'd5, 1'b0, 32'd9, 32'd2, 32'd0, 5'd7, 0);
        do_op(2'b10, 3'd2, 1'b0, 32'd9, 32'd2, 32'd0, 5'd8, 1);
        do_op(2'b11, 3'd0, 1'b0, 32'd9, 32'd2, 32'd0, 5'd9, 0);

        // asynchronous reset while an op sits in EXEC
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'b00;
        bus.req_funct3 = 3'd0;
        bus.req_rs1   = 32'd100;
        bus.req_rs2   = 32'd23;
        bus.req_rd    = 5'd11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_exec", bus.req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_op_count", op_count, 0);
        chk("async_rst_op_count_w2", op_count2, 0);
        chk("async_rst_rsp_rd", bus.rsp_rd, 0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_async_rsp_valid", bus.rsp_valid, 0);
            chk("post_async_req_ready", bus.req_ready, 1);
        end

        // four completions wrap the 2-bit counter back to zero
        for (int i = 0; i < 4; i++) begin
            do_op(2'b01, 3'd4, 1'b0, pick_val(), 32'd0, pick_val(), 5'(i), 0);
        end
        chk("wrap_w2_zero", op_count2, 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            do_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  pick_val(), pick_val(), pick_val(), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
